// File: rtl/irq_ctl_pkg.sv
// Shared constants for the interrupt front end.
// Contents: request kinds, fixed vectors, register addresses and FSM states.
package irq_ctl_pkg;

  // Request kind presented to ctl
  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_IRQ  = 2'b01;
  localparam logic [1:0] K_NMI  = 2'b10;
  localparam logic [1:0] K_RST  = 2'b11;

  // Fixed 65C02 vectors
  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  // Register map
  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_ACTIVE  = 2'd2;
  localparam logic [1:0] A_SWI     = 2'd3;

  // Request FSM
  typedef logic [1:0] state_t;
  localparam state_t S_RST   = 2'd0;
  localparam state_t S_IDLE  = 2'd1;
  localparam state_t S_ARM_N = 2'd2;
  localparam state_t S_ARM_I = 2'd3;

endpackage

// File: rtl/irq_sync.sv
// SYNC-deep, WIDTH-wide flop chain for asynchronous interrupt sources.
// SYNC=0 passes the input straight through for already-synchronous sources.
module irq_sync #(
  parameter int SYNC  = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (SYNC == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = clk ^ rst_n;
      assign q = d;
    end else begin : g_flops
      logic [WIDTH-1:0] stg [SYNC];

      // Shift the source through the chain; runs every cycle, independent of rdy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC; i++) stg[i] <= '0;
        end else begin
          stg[0] <= d;
          for (int i = 1; i < SYNC; i++) stg[i] <= stg[i-1];
        end
      end

      assign q = stg[SYNC-1];
    end
  endgenerate

endmodule

// File: rtl/irq_ctl.sv
// Interrupt front end for the 65C02 core: NIRQ prioritised, maskable,
// optionally vectored IRQ channels, an edge-latched NMI and a power-on
// reset request, presented to ctl as one take/kind/vec request.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int          NIRQ     = 8,
  parameter int          SYNC     = 2,
  parameter bit          VECTORED = 1'b1,
  parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
  input  logic            clk,
  input  logic            RST_N,
  input  logic            rdy,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            nmi,
  input  logic            sync,
  input  logic            I,
  input  logic            ack,
  output logic            take,
  output logic [1:0]      kind,
  output logic [15:0]     vec,
  input  logic            reg_we,
  input  logic [1:0]      reg_addr,
  input  logic [7:0]      reg_di,
  output logic [7:0]      reg_do
);

  logic [NIRQ-1:0] irq_s;
  logic            nmi_s;
  logic            nmi_s_d;
  logic            nmi_rise;
  logic            nmi_pend;
  logic            nmi_clr;

  state_t          state;
  logic [2:0]      ch;
  logic            committed;

  logic [NIRQ-1:0] enable;
  logic [NIRQ-1:0] swi;
  logic [NIRQ-1:0] swi_set;
  logic [NIRQ-1:0] swi_clr;
  logic            active_vld;
  logic [2:0]      active_ch;

  logic [NIRQ-1:0] pending;
  logic [7:0]      pend8;
  logic [7:0]      ch_oh;
  logic [2:0]      sel;
  logic            ack_ok;

  irq_sync #(.SYNC(SYNC), .WIDTH(NIRQ)) u_sync_irq (
    .clk   (clk),
    .rst_n (RST_N),
    .d     (irq_in),
    .q     (irq_s)
  );

  irq_sync #(.SYNC(SYNC), .WIDTH(1)) u_sync_nmi (
    .clk   (clk),
    .rst_n (RST_N),
    .d     (nmi),
    .q     (nmi_s)
  );

  assign pending  = (irq_s | swi) & enable;
  assign pend8    = 8'(pending);
  assign ch_oh    = 8'd1 << ch;
  assign ack_ok   = rdy && ack;
  assign nmi_rise = nmi_s && !nmi_s_d;
  // An NMI is retired at its own ack; a stale one is dropped at the reset ack
  assign nmi_clr  = ack_ok && (state == S_ARM_N || state == S_RST);
  assign swi_set  = (rdy && reg_we && reg_addr == A_SWI) ? reg_di[NIRQ-1:0] : '0;
  assign swi_clr  = (ack_ok && state == S_ARM_I) ? ch_oh[NIRQ-1:0] : '0;

  // Lowest-numbered pending channel has priority
  always_comb begin
    sel = 3'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pending[i]) sel = 3'(i);
    end
  end

  // NMI edge detect: runs through rdy=0 so edges are never lost; a new edge beats a clear
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      nmi_s_d  <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_s_d <= nmi_s;
      if (nmi_rise)     nmi_pend <= 1'b1;
      else if (nmi_clr) nmi_pend <= 1'b0;
    end
  end

  // Request FSM; an IRQ seen at an instruction boundary is committed until ack
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_RST;
      ch        <= 3'd0;
      committed <= 1'b0;
    end else if (rdy) begin
      case (state)
        S_RST: begin
          if (ack) state <= S_IDLE;
        end
        S_IDLE: begin
          if (nmi_pend) begin
            state <= S_ARM_N;
          end else if (|pending && !I) begin
            state <= S_ARM_I;
            ch    <= sel;
          end
        end
        S_ARM_N: begin
          if (ack) state <= S_IDLE;
        end
        S_ARM_I: begin
          if (ack) begin
            state     <= S_IDLE;
            committed <= 1'b0;
          end else if (sync || committed) begin
            committed <= 1'b1;
          end else if (nmi_pend) begin
            state <= S_ARM_N;
          end else if (!pend8[ch] || I) begin
            state <= S_IDLE;
          end else begin
            ch <= sel;
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

  // ENABLE and SWI registers; an acked channel's SWI bit self-clears
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      enable <= '0;
      swi    <= '0;
    end else if (rdy) begin
      if (reg_we && reg_addr == A_ENABLE) enable <= reg_di[NIRQ-1:0];
      swi <= (swi & ~swi_clr) | swi_set;
    end
  end

  // ACTIVE tracks the last IRQ taken; any other kind of ack invalidates it
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      active_vld <= 1'b0;
      active_ch  <= 3'd0;
    end else if (ack_ok) begin
      if (state == S_ARM_I) begin
        active_vld <= 1'b1;
        active_ch  <= ch;
      end else if (state == S_RST || state == S_ARM_N) begin
        active_vld <= 1'b0;
      end
    end
  end

  // Request outputs decoded from the registered state and channel
  always_comb begin
    take = 1'b0;
    kind = K_NONE;
    vec  = VEC_IRQ;
    case (state)
      S_RST: begin
        take = 1'b1;
        kind = K_RST;
        vec  = VEC_RST;
      end
      S_ARM_N: begin
        take = 1'b1;
        kind = K_NMI;
        vec  = VEC_NMI;
      end
      S_ARM_I: begin
        take = 1'b1;
        kind = K_IRQ;
        if (VECTORED) vec = VEC_BASE + {12'd0, ch, 1'b0};
        else          vec = VEC_IRQ;
      end
      default: ;
    endcase
  end

  // Register read mux
  always_comb begin
    reg_do = 8'h00;
    case (reg_addr)
      A_ENABLE:  reg_do = 8'(enable);
      A_PENDING: reg_do = pend8;
      A_ACTIVE:  reg_do = {active_vld, 4'b0000, active_ch};
      A_SWI:     reg_do = 8'(swi);
      default:   reg_do = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: a vectored instance and a non-vectored twin share stimulus.
module tb_irq_ctl;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        rdy, nmi, sync, i_flag, ack, reg_we;
  logic [7:0]  irq_in;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_di;
  logic        take, nv_take;
  logic [1:0]  kind, nv_kind;
  logic [15:0] vec, nv_vec;
  logic [7:0]  reg_do, nv_reg_do;

  irq_ctl u_dut (
    .clk(clk), .RST_N(RST_N), .rdy(rdy), .irq_in(irq_in), .nmi(nmi),
    .sync(sync), .I(i_flag), .ack(ack), .take(take), .kind(kind), .vec(vec),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_di(reg_di), .reg_do(reg_do)
  );

  irq_ctl #(.VECTORED(1'b0)) u_nv (
    .clk(clk), .RST_N(RST_N), .rdy(rdy), .irq_in(irq_in), .nmi(nmi),
    .sync(sync), .I(i_flag), .ack(ack), .take(nv_take), .kind(nv_kind), .vec(nv_vec),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_di(reg_di), .reg_do(nv_reg_do)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy, sync, i_f, ack, nmi;
    logic [7:0] irq;
    logic       we;
    logic [1:0] addr;
    logic [7:0] di;
    logic       take;
    logic [1:0] kind;
    logic [15:0] vec;
    logic       chk_do;
    logic [7:0] dov;
  } row_t;

  typedef struct packed {
    logic        take;
    logic [1:0]  kind;
    logic [15:0] vec;
    logic        chk_do;
    logic [7:0]  dov;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad   = 0;
  row_t  tbl [13];

  function automatic row_t mk(input logic r, input logic s, input logic i, input logic a,
                              input logic n, input logic [7:0] irq, input logic we,
                              input logic [1:0] ad, input logic [7:0] di, input logic t,
                              input logic [1:0] k, input logic [15:0] v, input logic cd,
                              input logic [7:0] d);
    row_t x;
    x = '{r, s, i, a, n, irq, we, ad, di, t, k, v, cd, d};
    return x;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic check_pop();
    exp_t        e;
    string       nm;
    logic [15:0] nv_req;
    e  = exp_q.pop_front();
    nm = nm_q.pop_front();
    nv_req = (e.kind == 2'b01) ? 16'hFFFE : e.vec;
    chk({nm, ".take"}, 16'(take), 16'(e.take));
    chk({nm, ".kind"}, 16'(kind), 16'(e.kind));
    chk({nm, ".vec"}, vec, e.vec);
    chk({nm, ".nv_take"}, 16'(nv_take), 16'(e.take));
    chk({nm, ".nv_kind"}, 16'(nv_kind), 16'(e.kind));
    chk({nm, ".nv_vec"}, nv_vec, nv_req);
    if (e.chk_do) begin
      chk({nm, ".reg_do"}, 16'(reg_do), 16'(e.dov));
      chk({nm, ".nv_reg_do"}, 16'(nv_reg_do), 16'(e.dov));
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the edge
  task automatic cyc(input row_t r, input string nm);
    rdy = r.rdy; sync = r.sync; i_flag = r.i_f; ack = r.ack; nmi = r.nmi;
    irq_in = r.irq; reg_we = r.we; reg_addr = r.addr; reg_di = r.di;
    exp_q.push_back(exp_t'{r.take, r.kind, r.vec, r.chk_do, r.dov});
    nm_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    check_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset vector and basic vectored IRQ with channel upgrade
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b1,2'd3,16'hFFFC,1'b1,8'h00);
    tbl[1]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b1,2'd3,16'hFFFC,1'b0,8'h00);
    tbl[2]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00);
    tbl[3]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h00);
    tbl[4]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,2'd0,8'hFF, 1'b0,2'd0,16'hFFFE,1'b1,8'h00);
    tbl[5]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,2'd0,8'h0C, 1'b0,2'd0,16'hFFFE,1'b1,8'h0C);
    tbl[6]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h08,1'b0,2'd1,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h00);
    tbl[7]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h0C,1'b0,2'd1,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h08);
    tbl[8]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h0C,1'b0,2'd1,8'h00, 1'b1,2'd1,16'hFFE6,1'b1,8'h0C);
    tbl[9]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h0C,1'b0,2'd1,8'h00, 1'b1,2'd1,16'hFFE4,1'b1,8'h0C);
    tbl[10] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,8'h0C,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE4,1'b1,8'h00);
    tbl[11] = mk(1'b1,1'b0,1'b1,1'b1,1'b0,8'h0C,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h82);
    tbl[12] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b1,2'd0,8'h01, 1'b0,2'd0,16'hFFFE,1'b1,8'h01);

    RST_N = 1'b0; rdy = 1'b1; nmi = 1'b0; sync = 1'b0; i_flag = 1'b0; ack = 1'b0;
    irq_in = 8'h00; reg_we = 1'b0; reg_addr = 2'd0; reg_di = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst.take", 16'(take), 16'h1);
    chk("rst.kind", 16'(kind), 16'h3);
    chk("rst.vec", vec, 16'hFFFC);
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #1;
      chk($sformatf("rst.reg_do%0d", a), 16'(reg_do), 16'h0);
    end
    reg_addr = 2'd0;
    @(negedge clk);
    RST_N = 1'b1;

    for (int k = 0; k < 13; k++) cyc(tbl[k], $sformatf("row%0d", k));

    // Withdraw before the boundary, then hold once committed
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h82), "wd_a");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h82), "wd_b");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b1,8'h82), "wd_c");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b1,8'h82), "wd_d");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b1,8'h82), "wd_e");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h82), "wd_f");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "cm_a");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "cm_b");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b0,8'h00), "cm_c");
    cyc(mk(1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b0,8'h00), "cm_d");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b0,8'h00), "cm_e");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b0,8'h00), "cm_f");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b1,8'h82), "cm_g");
    cyc(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h80), "cm_ack");

    // NMI upgrades an armed IRQ, IRQ re-arms after the NMI ack
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "up_a");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "up_b");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b0,8'h00), "up_c");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b1,8'h01,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b0,8'h00), "up_d");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b1,8'h01,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b0,8'h00), "up_e");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b0,8'h00), "up_f");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b1,2'd2,16'hFFFA,1'b0,8'h00), "up_nmi");
    cyc(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h00), "up_ack");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h01,1'b0,2'd2,8'h00, 1'b1,2'd1,16'hFFE0,1'b0,8'h00), "up_rearm");
    cyc(mk(1'b1,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h80), "up_ack2");

    // NMI edge while rdy=0, then a second edge landing on the ack
    cyc(mk(1'b0,1'b0,1'b1,1'b0,1'b1,8'h00,1'b0,2'd0,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "rd_a");
    cyc(mk(1'b0,1'b0,1'b1,1'b0,1'b1,8'h00,1'b0,2'd0,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "rd_b");
    cyc(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "rd_c");
    cyc(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "rd_d");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b1,2'd2,16'hFFFA,1'b0,8'h00), "rd_go");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b1,8'h00,1'b0,2'd0,8'h00, 1'b1,2'd2,16'hFFFA,1'b0,8'h00), "e2_a");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b1,8'h00,1'b0,2'd0,8'h00, 1'b1,2'd2,16'hFFFA,1'b0,8'h00), "e2_b");
    cyc(mk(1'b1,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "e2_ack");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b1,2'd2,16'hFFFA,1'b0,8'h00), "e2_again");
    cyc(mk(1'b1,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "e2_ack2");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b0,2'd0,16'hFFFE,1'b0,8'h00), "e2_idle");

    // Software IRQ on channel 4 gated by I
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b1,2'd3,8'h10, 1'b0,2'd0,16'hFFFE,1'b1,8'h10), "sw_wr");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b1,2'd0,8'h10, 1'b0,2'd0,16'hFFFE,1'b1,8'h10), "sw_en");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,2'd1,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h10), "sw_mask_a");
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,2'd1,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h10), "sw_mask_b");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,2'd3,8'h00, 1'b1,2'd1,16'hFFE8,1'b1,8'h10), "sw_take");
    cyc(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,2'd3,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h00), "sw_ack");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,2'd2,8'h00, 1'b0,2'd0,16'hFFFE,1'b1,8'h84), "sw_active");

    // Reset asserted in the middle of an armed request
    cyc(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b1,2'd3,8'h10, 1'b0,2'd0,16'hFFFE,1'b1,8'h10), "mr_wr");
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b1,2'd1,16'hFFE8,1'b1,8'h10), "mr_arm");
    #1 RST_N = 1'b0;
    #1;
    chk("mr.take", 16'(take), 16'h1);
    chk("mr.kind", 16'(kind), 16'h3);
    chk("mr.vec", vec, 16'hFFFC);
    chk("mr.enable", 16'(reg_do), 16'h0);
    reg_addr = 2'd3;
    #1 chk("mr.swi", 16'(reg_do), 16'h0);
    reg_addr = 2'd2;
    #1 chk("mr.active", 16'(reg_do), 16'h0);
    @(negedge clk);
    RST_N = 1'b1;
    cyc(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,8'h00, 1'b1,2'd3,16'hFFFC,1'b1,8'h00), "mr_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
